seq_tx_fmt: RTL and testbench



---
 rtl/seq_tx_fmt_pkg.sv | 26 ++
 rtl/seq_tx_fmt.sv | 142 ++++++++++++++
 tb/tb_seq_tx_fmt.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_tx_fmt_pkg.sv
// Shared definitions for the sequencer-to-UART hex line formatter:
// ASCII control characters, FSM state encoding and nibble-to-ASCII mapping.
package seq_tx_fmt_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  // Uppercase hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    logic [7:0] asc_s;
    if (nib < 4'd10) begin
      asc_s = 8'h30 + {4'h0, nib};
    end else begin
      asc_s = 8'h37 + {4'h0, nib};
    end
    return asc_s;
  endfunction

endpackage

// File: rtl/seq_tx_fmt.sv
// Captures one sequencer result per strobe and sends it to the UART as
// uppercase hex text (MS nibble first) followed by CR LF, paced by UART busy.
module seq_tx_fmt
  import seq_tx_fmt_pkg::*;
#(
  parameter  int DW  = 16,
  localparam int NCH = DW / 4 + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_tx_data,
  input  logic          i_tx_stb,
  output logic          o_tx_busy,
  output logic          o_drop,
  output logic [7:0]    o_uart_data,
  output logic          o_uart_stb,
  input  logic          i_uart_busy
);

  localparam int             IW       = $clog2(NCH);
  localparam logic [IW-1:0]  CR_IDX   = IW'(DW / 4);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NCH - 1);

  state_e          state_r;
  state_e          state_nxt_s;
  logic [DW-1:0]   shift_r;
  logic [IW-1:0]   idx_r;
  logic            guard_r;
  logic            last_s;
  logic [7:0]      char_s;
  logic            stb_nxt_s;
  logic [7:0]      data_nxt_s;
  logic            drop_nxt_s;
  logic            busy_nxt_s;
  logic            uart_stb_r;
  logic [7:0]      uart_data_r;
  logic            drop_r;
  logic            busy_r;

  assign last_s = (idx_r == LAST_IDX);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; GUARD lasts two cycles to ride over the UART's registered busy rise
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_tx_stb) state_nxt_s = ST_SEND;
        else          state_nxt_s = ST_IDLE;
      end
      ST_SEND: begin
        if (!i_uart_busy) state_nxt_s = ST_GUARD;
        else              state_nxt_s = ST_SEND;
      end
      ST_GUARD: begin
        if (guard_r) state_nxt_s = ST_WAIT;
        else         state_nxt_s = ST_GUARD;
      end
      ST_WAIT: begin
        if (i_uart_busy) state_nxt_s = ST_WAIT;
        else if (last_s) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_SEND;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Character for the current index: hex digits from the top of the shift register, then CR, LF
  always_comb begin
    char_s = ASCII_LF;
    if (idx_r < CR_IDX) begin
      char_s = nib2ascii(shift_r[DW-1 -: 4]);
    end else if (idx_r == CR_IDX) begin
      char_s = ASCII_CR;
    end else begin
      char_s = ASCII_LF;
    end
  end

  // FSM output decode feeding the output registers
  always_comb begin
    stb_nxt_s  = (state_r == ST_SEND) && !i_uart_busy;
    drop_nxt_s = i_tx_stb && (state_r != ST_IDLE);
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    if (stb_nxt_s) begin
      data_nxt_s = char_s;
    end else begin
      data_nxt_s = uart_data_r;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r     <= {DW{1'b0}};
      idx_r       <= {IW{1'b0}};
      guard_r     <= 1'b0;
      uart_stb_r  <= 1'b0;
      uart_data_r <= 8'h00;
      drop_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      uart_stb_r  <= stb_nxt_s;
      uart_data_r <= data_nxt_s;
      drop_r      <= drop_nxt_s;
      busy_r      <= busy_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (i_tx_stb) begin
            shift_r <= i_tx_data;
            idx_r   <= {IW{1'b0}};
          end
        end
        ST_SEND: begin
          if (!i_uart_busy) begin
            guard_r <= 1'b0;
            if (idx_r < CR_IDX) shift_r <= shift_r << 3'd4;
          end
        end
        ST_GUARD: guard_r <= 1'b1;
        ST_WAIT: begin
          if (!i_uart_busy && !last_s) idx_r <= idx_r + IW'(1);
        end
        default: guard_r <= 1'b0;
      endcase
    end
  end

  assign o_uart_stb  = uart_stb_r;
  assign o_uart_data = uart_data_r;
  assign o_drop      = drop_r;
  assign o_tx_busy   = busy_r;

endmodule

// File: tb/tb_seq_tx_fmt.sv
// Self-checking bench for seq_tx_fmt: directed plus randomized words, expected
// text lines built from a hex-digit lookup table, with a small UART busy model.
module tb_seq_tx_fmt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] tx_data = 16'h0000;
  logic        tx_stb = 1'b0;
  logic        tx_busy, drop, uart_stb;
  logic [7:0]  uart_data;
  logic        uart_busy;
  logic        hold = 1'b0;
  int          busy_lat = 3;
  int          busy_cnt = 0;

  logic [7:0]  tx_data8 = 8'h00;
  logic        tx_stb8 = 1'b0;
  logic        tx_busy8, drop8, uart_stb8;
  logic [7:0]  uart_data8;
  logic        uart_busy8 = 1'b0;

  int n_assert = 0;
  int n_fail = 0;
  logic [7:0] got_q[$];
  logic [7:0] got8_q[$];
  int drop_cnt = 0;
  int gap_err = 0;
  int cyc = 0;
  int last_stb = -100;
  string hexd = "0123456789ABCDEF";

  seq_tx_fmt #(.DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_tx_data(tx_data), .i_tx_stb(tx_stb),
    .o_tx_busy(tx_busy), .o_drop(drop), .o_uart_data(uart_data),
    .o_uart_stb(uart_stb), .i_uart_busy(uart_busy));

  seq_tx_fmt #(.DW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .i_tx_data(tx_data8), .i_tx_stb(tx_stb8),
    .o_tx_busy(tx_busy8), .o_drop(drop8), .o_uart_data(uart_data8),
    .o_uart_stb(uart_stb8), .i_uart_busy(uart_busy8));

  always #5 clk = ~clk;

  // UART model: busy rises the cycle after a strobe and lasts busy_lat cycles
  assign uart_busy = (busy_cnt != 0) || hold;
  always @(posedge clk) begin
    if (uart_stb) busy_cnt <= busy_lat;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (uart_stb) begin
      got_q.push_back(uart_data);
      if (cyc - last_stb < 4) gap_err <= gap_err + 1;
      last_stb <= cyc;
    end
    if (uart_stb8) got8_q.push_back(uart_data8);
    if (drop) drop_cnt <= drop_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] w);
    @(negedge clk);
    tx_data = w;
    tx_stb = 1'b1;
    @(negedge clk);
    tx_stb = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (tx_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Expected line: hex digits MS first from a lookup string, then CR LF
  task automatic check_line(input string tag, input logic [15:0] w, input int ndig,
                            input int off, input bit use8);
    logic [7:0] e[$];
    logic [7:0] g;
    for (int i = ndig - 1; i >= 0; i--) e.push_back(hexd[(w >> (4 * i)) % 16]);
    e.push_back(8'h0D);
    e.push_back(8'h0A);
    for (int i = 0; i < e.size(); i++) begin
      if (use8) g = (off + i < got8_q.size()) ? got8_q[off + i] : 8'hxx;
      else      g = (off + i < got_q.size())  ? got_q[off + i]  : 8'hxx;
      chk($sformatf("%s_ch%0d", tag, i), {24'h0, g}, {24'h0, e[i]});
    end
  endtask

  initial begin
    int sofar;
    int n;
    bit stb_seen;
    logic [15:0] w;
    logic [7:0] w8;

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, tx_busy}, 32'd0);
    chk("rst_stb", {31'h0, uart_stb}, 32'd0);
    chk("rst_data", {24'h0, uart_data}, 32'd0);
    chk("rst_drop", {31'h0, drop}, 32'd0);
    chk("rst8_busy", {31'h0, tx_busy8}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic line 0x12AB
    busy_lat = 3;
    send(16'h12AB);
    chk("busy_after_stb", {31'h0, tx_busy}, 32'd1);
    wait_idle("basic");
    repeat (4) @(negedge clk);
    chk("basic_count", got_q.size(), 32'd6);
    check_line("basic", 16'h12AB, 4, 0, 1'b0);
    chk("basic_busy_low", {31'h0, tx_busy}, 32'd0);
    got_q.delete();

    // UART busy held for 50 cycles at the start of SEND
    hold = 1'b1;
    send(16'h1A2B);
    stb_seen = 1'b0;
    repeat (49) begin
      @(negedge clk);
      if (uart_stb) stb_seen = 1'b1;
    end
    chk("hold_no_stb", {31'h0, stb_seen}, 32'd0);
    hold = 1'b0;
    @(negedge clk);
    chk("hold_release_stb", {31'h0, uart_stb}, 32'd1);
    chk("hold_release_data", {24'h0, uart_data}, 32'h31);
    wait_idle("hold");
    check_line("hold", 16'h1A2B, 4, 0, 1'b0);
    got_q.delete();

    // Strobe while a line is in flight is dropped
    sofar = drop_cnt;
    send(16'h0009);
    n = 0;
    while (got_q.size() < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    send(16'hFFFF);
    chk("drop_pulse", {31'h0, drop}, 32'd1);
    wait_idle("drop");
    repeat (4) @(negedge clk);
    chk("drop_count", drop_cnt - sofar, 32'd1);
    chk("drop_line_count", got_q.size(), 32'd6);
    check_line("drop", 16'h0009, 4, 0, 1'b0);
    got_q.delete();

    // Back-to-back: new word accepted in the cycle busy falls
    sofar = drop_cnt;
    send(16'h0000);
    n = 0;
    while (tx_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    tx_data = 16'hBEEF;
    tx_stb = 1'b1;
    @(negedge clk);
    tx_stb = 1'b0;
    chk("b2b_busy", {31'h0, tx_busy}, 32'd1);
    wait_idle("b2b");
    repeat (4) @(negedge clk);
    chk("b2b_count", got_q.size(), 32'd12);
    chk("b2b_nodrop", drop_cnt - sofar, 32'd0);
    check_line("b2b_a", 16'h0000, 4, 0, 1'b0);
    check_line("b2b_b", 16'hBEEF, 4, 6, 1'b0);
    got_q.delete();

    // Reset in the middle of a line
    send(16'hC0DE);
    n = 0;
    while (got_q.size() < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", {31'h0, tx_busy}, 32'd0);
    chk("mrst_stb", {31'h0, uart_stb}, 32'd0);
    chk("mrst_data", {24'h0, uart_data}, 32'd0);
    chk("mrst_drop", {31'h0, drop}, 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("mrst_no_more", got_q.size(), 32'd2);
    got_q.delete();
    send(16'h0001);
    wait_idle("post_rst");
    repeat (4) @(negedge clk);
    chk("post_rst_count", got_q.size(), 32'd6);
    check_line("post_rst", 16'h0001, 4, 0, 1'b0);
    got_q.delete();

    // Random words with random UART busy lengths
    for (int k = 0; k < 12; k++) begin
      w = 16'($urandom);
      busy_lat = $urandom_range(1, 6);
      send(w);
      wait_idle("rnd");
      repeat (8) @(negedge clk);
      chk("rnd_count", got_q.size(), 32'd6);
      check_line($sformatf("rnd%0d", k), w, 4, 0, 1'b0);
      got_q.delete();
    end

    // DW=8 instance
    tx_data8 = 8'h5F;
    @(negedge clk);
    tx_stb8 = 1'b1;
    @(negedge clk);
    tx_stb8 = 1'b0;
    repeat (40) @(negedge clk);
    chk("dw8_count", got8_q.size(), 32'd4);
    check_line("dw8", 16'h005F, 2, 0, 1'b1);
    chk("dw8_busy_low", {31'h0, tx_busy8}, 32'd0);
    got8_q.delete();
    w8 = 8'($urandom);
    tx_data8 = w8;
    @(negedge clk);
    tx_stb8 = 1'b1;
    @(negedge clk);
    tx_stb8 = 1'b0;
    repeat (40) @(negedge clk);
    check_line("dw8_rnd", {8'h00, w8}, 2, 0, 1'b1);

    chk("stb_spacing", gap_err, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
